// File: rtl/ahb_sram_arb.sv
// Round-robin arbiter that shares one AHB-Lite SRAM slave between NREQ request/response clients.
// Issues one SINGLE NONSEQ transfer per grant, waits out slave wait states, then returns data or error.
module ahb_sram_arb #(
    parameter int NREQ        = 2,
    parameter int HADDR_WIDTH = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int RD_WAIT     = 0
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_write,
    input  logic [NREQ*HADDR_WIDTH-1:0]   req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NREQ*DATA_WIDTH/8-1:0]  req_wstrb,
    output logic [NREQ-1:0]               req_ready,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          hsel,
    output logic [HADDR_WIDTH-1:0]        haddr,
    output logic [1:0]                    htrans,
    output logic                          hwrite,
    output logic [2:0]                    hsize,
    output logic [2:0]                    hburst,
    output logic [DATA_WIDTH-1:0]         hwdata,
    output logic [DATA_WIDTH/8-1:0]       hwstrb,
    output logic                          hready,
    input  logic [DATA_WIDTH-1:0]         hrdata,
    input  logic                          hreadyout,
    input  logic                          hresp
);

    localparam int         PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         STRB_W    = DATA_WIDTH / 8;
    localparam logic [2:0] FULL_SIZE = 3'($clog2(STRB_W));
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RWAIT, S_RESP} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt;
    logic [PTR_W-1:0] pick;
    logic [2:0]       cnt;

    // First set request bit at or above ptr, wrapping; lowest offset wins.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [PTR_W-1:0] ptr);
        rr_pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) j -= NREQ;
            if (v[j]) rr_pick = PTR_W'(j);
        end
    endfunction

    assign pick = rr_pick(req_valid, rr_ptr);

    // The accept pulse is combinational so it lands in the grant cycle; held low during reset.
    assign req_ready = (state == S_IDLE && !hreset && |req_valid) ? (NREQ'(1) << pick) : '0;
    assign hready    = hreadyout;
    assign hburst    = 3'b000;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch sees pre-edge values; defaults at the top keep one-cycle pulses self-clearing.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            cnt       <= '0;
            hsel      <= 1'b0;
            htrans    <= TR_IDLE;
            hwrite    <= 1'b0;
            hsize     <= 3'b000;
            haddr     <= '0;
            hwdata    <= '0;
            hwstrb    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        gnt    <= pick;
                        haddr  <= req_addr[int'(pick)*HADDR_WIDTH +: HADDR_WIDTH];
                        hwrite <= req_write[pick];
                        hwdata <= req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        hwstrb <= req_wstrb[int'(pick)*STRB_W +: STRB_W];
                        rr_ptr <= (pick == PTR_W'(NREQ - 1)) ? '0 : pick + 1'b1;
                        hsel   <= 1'b1;
                        htrans <= TR_NONSEQ;
                        hsize  <= FULL_SIZE;
                        busy   <= 1'b1;
                        state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (hreadyout) begin
                        hsel   <= 1'b0;
                        htrans <= TR_IDLE;
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    // hresp with hreadyout low is the first ERROR cycle; wait for the second.
                    if (hreadyout) begin
                        if (hresp) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_valid <= NREQ'(1) << gnt;
                            state     <= S_RESP;
                        end else if (hwrite) begin
                            rsp_rdata <= '0;
                            rsp_valid <= NREQ'(1) << gnt;
                            state     <= S_RESP;
                        end else if (RD_WAIT == 0) begin
                            rsp_rdata <= hrdata;
                            rsp_valid <= NREQ'(1) << gnt;
                            state     <= S_RESP;
                        end else begin
                            cnt   <= 3'(RD_WAIT);
                            state <= S_RWAIT;
                        end
                    end
                end
                S_RWAIT: begin
                    if (cnt == 3'd1) begin
                        rsp_rdata <= hrdata;
                        rsp_valid <= NREQ'(1) << gnt;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_arb.sv
// Directed bench for ahb_sram_arb: a zero-wait SRAM model with injectable wait/error
// responses on one instance, and a RD_WAIT=2 instance fed with a cycle-stamped hrdata.
module tb_ahb_sram_arb;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic hreset;
    int   cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Main instance (RD_WAIT = 0)
    logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*SW-1:0] req_wstrb;
    logic [DW-1:0]      rsp_rdata, hwdata, hrdata;
    logic               rsp_err, busy, hsel, hwrite, hready;
    logic [AW-1:0]      haddr;
    logic [1:0]         htrans;
    logic [2:0]         hsize, hburst;
    logic [SW-1:0]      hwstrb;
    logic               s_ready, s_resp;

    ahb_sram_arb #(.NREQ(NREQ), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(0)) dut (
        .hclk(clk), .hreset(hreset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready),
        .hrdata(hrdata), .hreadyout(s_ready), .hresp(s_resp)
    );

    // Second instance (RD_WAIT = 2), slave always ready, hrdata = cycle number
    logic [NREQ-1:0]    w_req_valid, w_req_write, w_req_ready, w_rsp_valid;
    logic [NREQ*AW-1:0] w_req_addr;
    logic [NREQ*DW-1:0] w_req_wdata;
    logic [NREQ*SW-1:0] w_req_wstrb;
    logic [DW-1:0]      w_rsp_rdata, w_hwdata, w_hrdata;
    logic               w_rsp_err, w_busy, w_hsel, w_hwrite, w_hready;
    logic [AW-1:0]      w_haddr;
    logic [1:0]         w_htrans;
    logic [2:0]         w_hsize, w_hburst;
    logic [SW-1:0]      w_hwstrb;

    assign w_hrdata = 32'(cyc_n);

    ahb_sram_arb #(.NREQ(NREQ), .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(2)) dut_w (
        .hclk(clk), .hreset(hreset),
        .req_valid(w_req_valid), .req_write(w_req_write), .req_addr(w_req_addr),
        .req_wdata(w_req_wdata), .req_wstrb(w_req_wstrb), .req_ready(w_req_ready),
        .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err), .busy(w_busy),
        .hsel(w_hsel), .haddr(w_haddr), .htrans(w_htrans), .hwrite(w_hwrite), .hsize(w_hsize),
        .hburst(w_hburst), .hwdata(w_hwdata), .hwstrb(w_hwstrb), .hready(w_hready),
        .hrdata(w_hrdata), .hreadyout(1'b1), .hresp(1'b0)
    );

    // SRAM model: address phase captured on hready, write committed at data-phase completion.
    logic [DW-1:0] mem [0:63];
    logic          ap_v, ap_w;
    logic [5:0]    ap_i;

    always @(posedge clk) begin
        if (hreset) begin
            ap_v <= 1'b0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (s_ready) begin
            if (ap_v && ap_w && !s_resp)
                for (int b = 0; b < SW; b++)
                    if (hwstrb[b]) mem[ap_i][b*8 +: 8] <= hwdata[b*8 +: 8];
            ap_v <= hsel && htrans == 2'b10;
            ap_i <= haddr[7:2];
            ap_w <= hwrite;
        end
    end
    assign hrdata = ap_v ? mem[ap_i] : '0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; returns #1 later in the cycle where the condition holds.
    task automatic wait_ready(input logic [NREQ-1:0] mask, input string tag);
        int n = 0;
        #1;
        while (!(|(req_ready & mask)) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 40) check({tag, "_ready_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        #1;
        while (!(|rsp_valid) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 40) check({tag, "_rsp_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic run_xfer(input string tag, input int c, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s, input int dwait,
                            input logic inj_err, output logic [31:0] rd, output logic er,
                            output int lat);
        int t0;
        @(negedge clk);
        req_valid[c]            = 1'b1;
        req_write[c]            = wr;
        req_addr[c*AW +: AW]    = a;
        req_wdata[c*DW +: DW]   = d;
        req_wstrb[c*SW +: SW]   = s;
        wait_ready(NREQ'(1) << c, tag);
        t0 = cyc_n;
        @(negedge clk);
        req_valid[c] = 1'b0;
        #1;
        check({tag, "_aphase"}, 64'({hsel, htrans, haddr, hwrite, hsize, hburst}),
              64'({1'b1, 2'b10, a, wr, 3'd2, 3'd0}));
        @(negedge clk);
        if (inj_err) begin
            s_resp  = 1'b1;
            s_ready = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < dwait; i++) begin
            s_ready = 1'b0;
            #1;
            check({tag, "_dhold"}, 64'({hsel, htrans, haddr, hwdata, hwstrb}),
                  64'({1'b0, 2'b00, a, d, s}));
            @(negedge clk);
        end
        s_ready = 1'b1;
        @(negedge clk);
        s_resp = 1'b0;
        wait_rsp(tag);
        check({tag, "_rsp_vec"}, 64'(rsp_valid), 64'(NREQ'(1) << c));
        rd  = rsp_rdata;
        er  = rsp_err;
        lat = cyc_n - t0;
    endtask

    logic [31:0]     rd;
    logic            er;
    int              lat, t0, prev_t;
    logic [NREQ-1:0] g, seen;

    initial begin
        hreset      = 1'b1;
        req_valid   = 2'b11;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        s_ready     = 1'b1;
        s_resp      = 1'b0;
        w_req_valid = '0;
        w_req_write = '0;
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_req_wstrb = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_ctrl", 64'({rsp_valid, rsp_err, busy, hsel, htrans, hwrite, hsize, hburst}), 64'(0));
        check("rst_haddr", 64'(haddr), 64'(0));
        check("rst_wdata", 64'({hwdata, hwstrb}), 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        s_ready = 1'b0; #1;
        check("hready_low", 64'(hready), 64'(0));
        s_ready = 1'b1; #1;
        check("hready_high", 64'(hready), 64'(1));
        req_valid = '0;
        @(negedge clk);
        hreset = 1'b0;

        // Write then read back, zero-wait
        run_xfer("wr10", 0, 1'b1, 32'h10, 32'hA5, 4'hF, 0, 1'b0, rd, er, lat);
        check("wr10_lat", 64'(lat), 64'(3));
        check("wr10_err", 64'(er), 64'(0));
        run_xfer("rd10", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        check("rd10_data", 64'(rd), 64'(32'hA5));
        check("rd10_lat", 64'(lat), 64'(3));

        // Byte strobes: only the low two bytes land
        run_xfer("wr14", 0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0011, 0, 1'b0, rd, er, lat);
        check("wr14_rdata_zero", 64'(rd), 64'(0));
        run_xfer("rd14", 1, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        check("rd14_strb_data", 64'(rd), 64'(32'h0000_FFFF));

        // Contention: both clients request continuously for 4 transfers
        @(negedge clk);
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = {32'h14, 32'h10};
        prev_t    = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(2'b11, "cont");
            g = req_ready;
            check("cont_grant", 64'(g), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            if (k > 0) check("cont_spacing", 64'(cyc_n - prev_t), 64'(4));
            prev_t = cyc_n;
            @(negedge clk);
            wait_rsp("cont");
            check("cont_rsp", 64'(rsp_valid), 64'(g));
            check("cont_data", 64'(rsp_rdata), 64'((g == 2'b01) ? 32'hA5 : 32'h0000_FFFF));
            if (k == 3) req_valid = '0;
            @(negedge clk);
        end

        // Two slave wait states in the data phase of a read
        run_xfer("wr20", 0, 1'b1, 32'h20, 32'hCAFE_0001, 4'hF, 0, 1'b0, rd, er, lat);
        run_xfer("rd20w", 0, 1'b0, 32'h20, 32'h1234_5678, 4'hA, 2, 1'b0, rd, er, lat);
        check("rd20w_data", 64'(rd), 64'(32'hCAFE_0001));
        check("rd20w_lat", 64'(lat), 64'(5));

        // Two-cycle ERROR response, then a clean transfer
        run_xfer("err", 1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, rd, er, lat);
        check("err_flag", 64'(er), 64'(1));
        check("err_lat", 64'(lat), 64'(4));
        run_xfer("post_err", 0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        check("post_err_flag", 64'(er), 64'(0));
        check("post_err_data", 64'(rd), 64'(32'hA5));

        // RD_WAIT = 2 instance: hrdata sampled two cycles after data-phase completion
        @(negedge clk);
        w_req_valid         = 2'b01;
        w_req_addr[0 +: AW] = 32'h40;
        #1;
        begin
            int n = 0;
            while (!w_req_ready[0] && n < 40) begin @(negedge clk); #1; n++; end
            if (n >= 40) check("rdw_ready_timeout", 64'(0), 64'(1));
            t0 = cyc_n;
            @(negedge clk);
            w_req_valid = '0;
            #1;
            n = 0;
            while (!(|w_rsp_valid) && n < 40) begin @(negedge clk); #1; n++; end
            if (n >= 40) check("rdw_rsp_timeout", 64'(0), 64'(1));
        end
        check("rdw_lat", 64'(cyc_n - t0), 64'(5));
        check("rdw_data", 64'(w_rsp_rdata), 64'(32'(t0 + 4)));
        check("rdw_rsp_vec", 64'(w_rsp_valid), 64'(2'b01));

        // Reset while in DATA: transfer dropped, pointer back to client 0
        @(negedge clk);
        req_valid            = 2'b01;
        req_write            = 2'b00;
        req_addr[0 +: AW]    = 32'h10;
        wait_ready(2'b01, "rstd");
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("rstd_in_data", 64'({busy, hsel, htrans}), 64'({1'b1, 1'b0, 2'b00}));
        hreset = 1'b1;
        @(negedge clk);
        #1;
        check("rstd_ctrl", 64'({rsp_valid, rsp_err, busy, hsel, htrans, hwrite, hsize}), 64'(0));
        check("rstd_addr_data", 64'({haddr, hwdata}), 64'(0));
        hreset = 1'b0;
        seen   = '0;
        repeat (4) begin
            @(negedge clk); #1;
            seen = seen | rsp_valid;
        end
        check("rstd_no_rsp", 64'(seen), 64'(0));
        req_valid = 2'b11;
        #1;
        check("rstd_rr_ptr", 64'(req_ready), 64'(2'b01));
        @(negedge clk);
        req_valid = '0;
        wait_rsp("rstd_next");
        check("rstd_next_rsp", 64'(rsp_valid), 64'(2'b01));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
